// File: rtl/icache_mt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_mt_pkg
// Purpose  : Shared widths, slowmem timing, miss-FSM encoding and the log2
//            helper used to derive the cache index width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package icache_mt_pkg;

    localparam int ADDR_W   = 16;   // default fetch/slowmem address width
    localparam int WORD_W   = 16;   // default instruction word width
    localparam int MEMDELAY = 4;    // nominal slowmem latency in cycles

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } miss_state_e;

    // Ceiling log2 for elaboration-time constants (v >= 1).
    function automatic int clog2i(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : icache_rr_arb
// Purpose  : Round-robin picker. Grants the first requester at or after the
//            pointer, wrapping around, and returns the pointer just past it.
// Ports    : req_i      - request vector, one bit per thread
//            ptr_i      - current round-robin pointer
//            grant_o    - one-hot grant (all zero when nothing requests)
//            any_o      - at least one request present
//            next_ptr_o - grant index + 1 mod NPID (ptr_i when idle)
// Revision : 1.0 - initial release
// ============================================================================
module icache_rr_arb #(
    parameter int NPID = 2,
    parameter int PW   = 1
) (
    input  logic [NPID-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NPID-1:0] grant_o,
    output logic            any_o,
    output logic [PW-1:0]   next_ptr_o
);

    // Two ascending passes: first from the pointer to the top, then from
    // zero. The first hit across both passes is the round-robin winner.
    always_comb begin
        grant_o    = '0;
        any_o      = 1'b0;
        next_ptr_o = ptr_i;
        for (int i = 0; i < NPID; i++) begin
            if (!any_o && req_i[i] && (i >= int'(ptr_i))) begin
                grant_o[i] = 1'b1;
                any_o      = 1'b1;
                next_ptr_o = (i == NPID - 1) ? '0 : PW'(i + 1);
            end
        end
        for (int i = 0; i < NPID; i++) begin
            if (!any_o && req_i[i]) begin
                grant_o[i] = 1'b1;
                any_o      = 1'b1;
                next_ptr_o = (i == NPID - 1) ? '0 : PW'(i + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_mt.sv
`default_nettype none
// ============================================================================
// Module   : icache_mt
// Purpose  : Multi-thread direct-mapped instruction cache, one word per line.
//            Combinational per-thread hit lookup, one outstanding miss to a
//            read-only slowmem port, store snooping and global invalidate.
// Ports    : clk, reset (async, active-low)
//            pc/ir/hit          - per-thread fetch address, word, hit flag
//            inv_all            - clear every valid bit
//            snoop_we/addr/data - data-side store to keep lines coherent
//            strobe/rnotw/addr  - slowmem request (registered)
//            mfc/rdata          - slowmem completion and read data
// Revision : 1.0 - initial release
// ============================================================================
module icache_mt
    import icache_mt_pkg::*;
#(
    parameter int NPID  = 2,
    parameter int LINES = 8,
    parameter int AW    = ADDR_W,
    parameter int DW    = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NPID*AW-1:0] pc,
    output logic [NPID*DW-1:0] ir,
    output logic [NPID-1:0]  hit,
    input  logic             inv_all,
    input  logic             snoop_we,
    input  logic [AW-1:0]    snoop_addr,
    input  logic [DW-1:0]    snoop_data,
    output logic             strobe,
    output logic             rnotw,
    output logic [AW-1:0]    addr,
    input  logic             mfc,
    input  logic [DW-1:0]    rdata
);

    localparam int IW = clog2i(LINES);
    localparam int TW = AW - IW;
    localparam int PW = (NPID > 1) ? clog2i(NPID) : 1;

    // Line storage
    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [DW-1:0]    data_q [LINES];

    // Miss engine state
    miss_state_e   state_q, state_d;
    logic          strobe_q, strobe_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [PW-1:0] rr_q, rr_d;
    logic          discard_q, discard_d;   // inv_all hit while miss pending
    logic          snpflag_q, snpflag_d;   // store to the miss address seen
    logic [DW-1:0] snpdata_q, snpdata_d;

    logic [NPID-1:0] w_grant;
    logic            w_any_miss;
    logic [PW-1:0]   w_rr_next;
    logic [AW-1:0]   w_sel_pc;
    logic            w_fill;
    logic [DW-1:0]   w_fill_data;
    logic            w_snoop_miss;
    logic            w_snoop_line;

    wire [IW-1:0] w_fidx = addr_q[IW-1:0];
    wire [TW-1:0] w_ftag = addr_q[AW-1:IW];
    wire [IW-1:0] w_sidx = snoop_addr[IW-1:0];
    wire [TW-1:0] w_stag = snoop_addr[AW-1:IW];

    // Per-thread combinational lookup
    for (genvar p = 0; p < NPID; p++) begin : g_port
        wire [AW-1:0] w_pc  = pc[p*AW +: AW];
        wire [IW-1:0] w_idx = w_pc[IW-1:0];
        assign hit[p]          = valid_q[w_idx] && (tag_q[w_idx] == w_pc[AW-1:IW]);
        assign ir[p*DW +: DW]  = data_q[w_idx];
    end

    icache_rr_arb #(
        .NPID (NPID),
        .PW   (PW)
    ) u_arb (
        .req_i      (~hit),
        .ptr_i      (rr_q),
        .grant_o    (w_grant),
        .any_o      (w_any_miss),
        .next_ptr_o (w_rr_next)
    );

    always_comb begin
        w_sel_pc = '0;
        for (int p = 0; p < NPID; p++) begin
            if (w_grant[p]) begin
                w_sel_pc = pc[p*AW +: AW];
            end
        end
    end

    assign w_snoop_miss = snoop_we && (snoop_addr == addr_q);
    assign w_snoop_line = snoop_we && valid_q[w_sidx] && (tag_q[w_sidx] == w_stag);

    // A store landing on the same edge as the fill supersedes the memory word
    // as well as any earlier captured store.
    assign w_fill_data = w_snoop_miss ? snoop_data :
                         (snpflag_q   ? snpdata_q  : rdata);

    always_comb begin
        state_d   = state_q;
        strobe_d  = 1'b0;
        addr_d    = addr_q;
        rr_d      = rr_q;
        discard_d = discard_q;
        snpflag_d = snpflag_q;
        snpdata_d = snpdata_q;
        w_fill    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_any_miss) begin
                    addr_d    = w_sel_pc;
                    strobe_d  = 1'b1;
                    rr_d      = w_rr_next;
                    discard_d = 1'b0;
                    snpflag_d = 1'b0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mfc) begin
                    w_fill  = !discard_q && !inv_all;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_q != ST_IDLE) begin
            if (w_snoop_miss) begin
                snpflag_d = 1'b1;
                snpdata_d = snoop_data;
            end
            if (inv_all) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            strobe_q  <= 1'b0;
            addr_q    <= '0;
            rr_q      <= '0;
            discard_q <= 1'b0;
            snpflag_q <= 1'b0;
            snpdata_q <= '0;
        end else begin
            state_q   <= state_d;
            strobe_q  <= strobe_d;
            addr_q    <= addr_d;
            rr_q      <= rr_d;
            discard_q <= discard_d;
            snpflag_q <= snpflag_d;
            snpdata_q <= snpdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (inv_all) begin
            valid_q <= '0;
        end else if (w_fill) begin
            valid_q[w_fidx] <= 1'b1;
        end
    end

    // Fill is written after the snoop so that a same-index fill with a
    // different tag replaces the line and the snoop is dropped.
    always_ff @(posedge clk) begin
        if (!inv_all) begin
            if (w_snoop_line) begin
                data_q[w_sidx] <= snoop_data;
            end
            if (w_fill) begin
                tag_q[w_fidx]  <= w_ftag;
                data_q[w_fidx] <= w_fill_data;
            end
        end
    end

    assign strobe = strobe_q;
    assign addr   = addr_q;
    assign rnotw  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_icache_mt.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_mt
// Purpose  : Directed self-checking bench for icache_mt (NPID=2, LINES=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_mt;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [1:0]  hit;
    logic        inv_all;
    logic        snoop_we;
    logic [15:0] snoop_addr;
    logic [15:0] snoop_data;
    logic        strobe;
    logic        rnotw;
    logic [15:0] addr;
    logic        mfc;
    logic [15:0] rdata;

    int nvec  = 0;
    int nfail = 0;
    int strobe_cnt = 0;

    icache_mt #(
        .NPID  (2),
        .LINES (8),
        .AW    (16),
        .DW    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .ir         (ir),
        .hit        (hit),
        .inv_all    (inv_all),
        .snoop_we   (snoop_we),
        .snoop_addr (snoop_addr),
        .snoop_data (snoop_data),
        .strobe     (strobe),
        .rnotw      (rnotw),
        .addr       (addr),
        .mfc        (mfc),
        .rdata      (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset === 1'b1 && strobe === 1'b1) strobe_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slowmem responder: waits (bounded) for a strobe, reports the address,
    // then answers 5 cycles after the strobe cycle. A store can be driven in
    // cycle snp_k counted from the strobe cycle (5 = same edge as mfc).
    task automatic serve(input logic [15:0] d, input int snp_k,
                         input logic [15:0] sa, input logic [15:0] sd,
                         output logic [15:0] got_addr, output bit ok);
        ok = 1'b0;
        got_addr = 16'hxxxx;
        for (int i = 0; i < 20; i++) begin
            if (strobe === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) return;
        got_addr = addr;
        for (int k = 0; k <= 5; k++) begin
            snoop_we   = (k == snp_k);
            snoop_addr = sa;
            snoop_data = sd;
            mfc        = (k == 5);
            rdata      = (k == 5) ? d : 16'h0000;
            tick();
        end
        snoop_we = 1'b0;
        mfc      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; pc = 32'h0; inv_all = 0; snoop_we = 0;
        snoop_addr = 0; snoop_data = 0; mfc = 0; rdata = 0;
        tick(); tick();
        nvec++; if (hit !== 2'b00) begin nfail++; $display("FAIL reset_hit: got %b expected 00", hit); end
        nvec++; if (strobe !== 1'b0) begin nfail++; $display("FAIL reset_strobe: got %b expected 0", strobe); end
        nvec++; if (addr !== 16'h0000) begin nfail++; $display("FAIL reset_addr: got %h expected 0000", addr); end
        nvec++; if (rnotw !== 1'b1) begin nfail++; $display("FAIL rnotw: got %b expected 1", rnotw); end
    endtask

    task automatic test_cold_miss();
        pc = {16'h0000, 16'h0000};
        reset = 1'b1;                       // cycle t
        #1;
        nvec++; if (hit[0] !== 1'b0 || strobe !== 1'b0) begin nfail++; $display("FAIL cold_t: got hit0=%b strobe=%b expected 0 0", hit[0], strobe); end
        tick();                             // t+1
        nvec++; if (strobe !== 1'b1 || addr !== 16'h0000) begin nfail++; $display("FAIL cold_req: got strobe=%b addr=%h expected 1 0000", strobe, addr); end
        tick();                             // t+2
        nvec++; if (strobe !== 1'b0) begin nfail++; $display("FAIL cold_pulse: got strobe=%b expected 0", strobe); end
        tick(); tick(); tick(); tick();     // t+6
        mfc = 1'b1; rdata = 16'h1234;
        #1;
        nvec++; if (hit[0] !== 1'b0) begin nfail++; $display("FAIL cold_t6: got hit0=%b expected 0", hit[0]); end
        tick();                             // t+7
        mfc = 1'b0;
        nvec++; if (hit !== 2'b11 || ir !== 32'h1234_1234) begin nfail++; $display("FAIL cold_fill: got hit=%b ir=%h expected 11 12341234", hit, ir); end
    endtask

    task automatic test_rr();
        logic [15:0] a; bit ok; int c0;
        reset = 1'b0; tick();
        pc = {16'h8005, 16'h0003};
        reset = 1'b1;
        c0 = strobe_cnt;
        serve(16'hA003, -1, 16'h0, 16'h0, a, ok);
        nvec++; if (!ok || a !== 16'h0003) begin nfail++; $display("FAIL rr1_first: got ok=%0d addr=%h expected 0003", ok, a); end
        serve(16'h5805, -1, 16'h0, 16'h0, a, ok);
        nvec++; if (!ok || a !== 16'h8005) begin nfail++; $display("FAIL rr1_second: got ok=%0d addr=%h expected 8005", ok, a); end
        tick(); tick();
        nvec++; if (strobe_cnt - c0 !== 2) begin nfail++; $display("FAIL rr1_strobes: got %0d expected 2", strobe_cnt - c0); end
        nvec++; if (hit !== 2'b11 || ir !== 32'h5805_A003) begin nfail++; $display("FAIL rr1_data: got hit=%b ir=%h expected 11 5805a003", hit, ir); end
        // Thread 0 alone misses, leaving thread 1 next in line.
        pc = {16'h8005, 16'h0004};
        serve(16'h0404, -1, 16'h0, 16'h0, a, ok);
        nvec++; if (!ok || a !== 16'h0004 || ir[15:0] !== 16'h0404) begin nfail++; $display("FAIL rr_single: got addr=%h ir0=%h expected 0004 0404", a, ir[15:0]); end
        pc = {16'h8007, 16'h0006};
        c0 = strobe_cnt;
        serve(16'h8707, -1, 16'h0, 16'h0, a, ok);
        nvec++; if (!ok || a !== 16'h8007) begin nfail++; $display("FAIL rr2_first: got ok=%0d addr=%h expected 8007", ok, a); end
        serve(16'h0606, -1, 16'h0, 16'h0, a, ok);
        nvec++; if (!ok || a !== 16'h0006) begin nfail++; $display("FAIL rr2_second: got ok=%0d addr=%h expected 0006", ok, a); end
        tick(); tick();
        nvec++; if (strobe_cnt - c0 !== 2) begin nfail++; $display("FAIL rr2_strobes: got %0d expected 2", strobe_cnt - c0); end
        nvec++; if (hit !== 2'b11 || ir !== 32'h8707_0606) begin nfail++; $display("FAIL rr2_data: got hit=%b ir=%h expected 11 87070606", hit, ir); end
    endtask

    task automatic test_conflict();
        logic [15:0] a; bit ok;
        pc = {16'h0003, 16'h0002};
        serve(16'h2222, -1, 16'h0, 16'h0, a, ok);
        nvec++; if (!ok || a !== 16'h0002 || hit !== 2'b11 || ir !== 32'hA003_2222) begin nfail++; $display("FAIL conf_fill: got addr=%h hit=%b ir=%h expected 0002 11 a0032222", a, hit, ir); end
        pc[15:0] = 16'h0012;
        #1;
        nvec++; if (hit !== 2'b10) begin nfail++; $display("FAIL conf_miss: got hit=%b expected 10", hit); end
        serve(16'h1212, -1, 16'h0, 16'h0, a, ok);
        nvec++; if (!ok || a !== 16'h0012 || hit[0] !== 1'b1 || ir[15:0] !== 16'h1212) begin nfail++; $display("FAIL conf_new: got addr=%h hit0=%b ir0=%h expected 0012 1 1212", a, hit[0], ir[15:0]); end
        pc[15:0] = 16'h0002;
        #1;
        nvec++; if (hit[0] !== 1'b0) begin nfail++; $display("FAIL conf_evicted: got hit0=%b expected 0", hit[0]); end
        serve(16'h2222, -1, 16'h0, 16'h0, a, ok);
        nvec++; if (!ok || a !== 16'h0002 || ir[15:0] !== 16'h2222) begin nfail++; $display("FAIL conf_back: got addr=%h ir0=%h expected 0002 2222", a, ir[15:0]); end
    endtask

    task automatic test_snoop();
        logic [15:0] a; bit ok; int c0;
        c0 = strobe_cnt;
        snoop_we = 1'b1; snoop_addr = 16'h0002; snoop_data = 16'hBEEF;
        tick();
        snoop_we = 1'b0;
        nvec++; if (hit[0] !== 1'b1 || ir[15:0] !== 16'hBEEF) begin nfail++; $display("FAIL snoop_hit: got hit0=%b ir0=%h expected 1 beef", hit[0], ir[15:0]); end
        // Same index, different tag: line untouched.
        snoop_we = 1'b1; snoop_addr = 16'h0012; snoop_data = 16'hDEAD;
        tick();
        snoop_we = 1'b0;
        tick();
        nvec++; if (hit[0] !== 1'b1 || ir[15:0] !== 16'hBEEF) begin nfail++; $display("FAIL snoop_other: got hit0=%b ir0=%h expected 1 beef", hit[0], ir[15:0]); end
        nvec++; if (strobe_cnt !== c0) begin nfail++; $display("FAIL snoop_nostrobe: got %0d expected %0d", strobe_cnt, c0); end
        pc[15:0] = 16'h0012;
        serve(16'h1212, -1, 16'h0, 16'h0, a, ok);
        // Store to the pending miss address during WAIT overrides memory data.
        pc[15:0] = 16'h0002;
        serve(16'h5555, 2, 16'h0002, 16'hBEEF, a, ok);
        nvec++; if (!ok || a !== 16'h0002 || hit[0] !== 1'b1 || ir[15:0] !== 16'hBEEF) begin nfail++; $display("FAIL snoop_wait: got addr=%h hit0=%b ir0=%h expected 0002 1 beef", a, hit[0], ir[15:0]); end
        // Same edge, same address: store data is written.
        pc[15:0] = 16'h0012;
        serve(16'h1111, 5, 16'h0012, 16'hCAFE, a, ok);
        nvec++; if (!ok || hit[0] !== 1'b1 || ir[15:0] !== 16'hCAFE) begin nfail++; $display("FAIL snoop_same_edge: got hit0=%b ir0=%h expected 1 cafe", hit[0], ir[15:0]); end
        // Same edge, same index, different tag: fill wins.
        pc[15:0] = 16'h0002;
        serve(16'h2020, 5, 16'h0012, 16'hF00D, a, ok);
        nvec++; if (!ok || hit !== 2'b11 || ir !== 32'hA003_2020) begin nfail++; $display("FAIL snoop_conflict_edge: got hit=%b ir=%h expected 11 a0032020", hit, ir); end
    endtask

    task automatic test_inv_all();
        bit ok;
        pc = {16'h0003, 16'h0012};
        #1;
        nvec++; if (hit !== 2'b10) begin nfail++; $display("FAIL inv_pre: got hit=%b expected 10", hit); end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (strobe === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        nvec++; if (!ok || addr !== 16'h0012) begin nfail++; $display("FAIL inv_req: got ok=%0d addr=%h expected 0012", ok, addr); end
        tick();                             // WAIT
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        nvec++; if (hit !== 2'b00) begin nfail++; $display("FAIL inv_drop: got hit=%b expected 00", hit); end
        tick();
        mfc = 1'b1; rdata = 16'h7777;
        tick();                             // back in IDLE, nothing written
        mfc = 1'b0;
        nvec++; if (hit !== 2'b00 || strobe !== 1'b0) begin nfail++; $display("FAIL inv_discard: got hit=%b strobe=%b expected 00 0", hit, strobe); end
        tick();                             // new miss round, thread 1 first
        nvec++; if (strobe !== 1'b1 || addr !== 16'h0003) begin nfail++; $display("FAIL inv_idle: got strobe=%b addr=%h expected 1 0003", strobe, addr); end
    endtask

    task automatic test_reset_mid_wait();
        tick(); tick();                     // inside WAIT
        reset = 1'b0;
        #1;
        nvec++; if (strobe !== 1'b0 || hit !== 2'b00 || addr !== 16'h0000) begin nfail++; $display("FAIL rst_mid: got strobe=%b hit=%b addr=%h expected 0 00 0000", strobe, hit, addr); end
        tick();
        pc = {16'h0020, 16'h0020};
        reset = 1'b1;
        mfc = 1'b1; rdata = 16'h9999;       // stray mfc in IDLE
        tick();                             // REQ, mfc still high
        nvec++; if (strobe !== 1'b1 || addr !== 16'h0020) begin nfail++; $display("FAIL rst_req: got strobe=%b addr=%h expected 1 0020", strobe, addr); end
        tick();
        mfc = 1'b0;
        nvec++; if (hit !== 2'b00) begin nfail++; $display("FAIL rst_stray: got hit=%b expected 00", hit); end
        tick(); tick(); tick(); tick();
        mfc = 1'b1; rdata = 16'hAAAA;
        tick();
        mfc = 1'b0;
        nvec++; if (hit !== 2'b11 || ir !== 32'hAAAA_AAAA) begin nfail++; $display("FAIL rst_refill: got hit=%b ir=%h expected 11 aaaaaaaa", hit, ir); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_rr();
        test_conflict();
        test_snoop();
        test_inv_all();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_mt.md
Name: icache_mt

Overview:
- Parametrised, multi-thread, direct-mapped instruction cache.
- Sits between the per-PID fetch stage of the processor and one read-only slowmem port (strobe/rnotw/mfc handshake).
- Serves NPID fetch ports with combinational hit lookup and services misses one at a time, with round-robin arbitration.
- Snoops data-side stores so cached instructions stay coherent, and supports a one-cycle global invalidate.

Parameters:
NPID, 2, number of thread fetch ports
LINES, 8, cache lines, one word per line; power of two, at least 2
AW, 16, address width
DW, 16, instruction word width
IW, log2(LINES), index width (derived, not overridable)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  reset, asynchronous, active-low
pc  in  NPID*AW  fetch addresses; thread p uses bits [p*AW +: AW]
ir  out  NPID*DW  instruction per thread; defined only when that thread's hit bit is 1
hit  out  NPID  per-thread hit, combinational from pc and the array
inv_all  in  1  invalidate all lines
snoop_we  in  1  data-side store occurred this cycle
snoop_addr  in  AW  store address
snoop_data  in  DW  store data
strobe  out  1  slowmem request strobe, registered
rnotw  out  1  always 1 (read)
addr  out  AW  slowmem address, registered
mfc  in  1  slowmem fetch complete
rdata  in  DW  slowmem read data, valid when mfc=1

Behaviour:
- Reset is asynchronous and active-low. When reset=0: all valid bits=0, FSM=IDLE, strobe=0, addr=0, round-robin pointer=0, pending flags cleared. hit=0 for all threads, so ir is don't-care.
- Address split: index = pc[IW-1:0], tag = pc[AW-1:IW].
- hit[p] = valid[idx] and tag[idx]==tag(pc_p); ir[p] = data[idx]. Same-cycle result, no added latency. All threads may hit simultaneously.
- Miss FSM states:
  - IDLE: if any thread misses, pick the first missing thread at or after the RR pointer. Latch its pc into addr, set strobe<=1, go to REQ. Advance the RR pointer to the selected thread +1, mod NPID.
  - REQ: strobe<=0, go to WAIT (strobe is high for exactly one cycle).
  - WAIT: on mfc=1, write data, tag and valid for the latched address and go to IDLE. Data is rdata, or the captured snoop data if a matching snoop occurred during the miss.
- Only one miss outstanding at a time. A thread whose pc changes while another thread's miss is pending simply keeps missing until arbitrated.
- The filled line is visible as a hit in the cycle after mfc. With slowmem MEMDELAY=4, a miss first presented in cycle t hits in cycle t+7.
- Snoop: when snoop_we=1 and a valid line matches snoop_addr, update its data at the edge. A non-matching or invalid line is unaffected (no allocate).
- Snoop during REQ/WAIT to the latched miss address: capture snoop_data and set a flag so the fill uses the snoop data. The last snoop wins.
- Fill and snoop at the same edge, same index:
  - same address: snoop data is written.
  - different tag: the fill replaces the line and the snoop is dropped.
- inv_all=1: all valid bits are cleared at the edge. If a miss is pending (REQ/WAIT), a discard flag is set. The mfc still completes the handshake, but no line is written. inv_all takes priority over a same-edge fill or snoop.
- mfc=1 while in IDLE or REQ is ignored.
- Reset asserted mid-miss aborts the FSM. A later stray mfc is ignored by the IDLE rule above.
- pc wrap-around at 2^AW needs no special handling.

Decomposition:
- Shared package: WORD/address widths, MEMDELAY, FSM state encodings (IDLE/REQ/WAIT), and the log2 helper for IW.
- One sub-module: icache_rr_arb (NPID-wide round-robin picker: request vector plus pointer in, one-hot grant and next pointer out).
- Tag/data/valid arrays stay inline.

Test Plan:
- Reset, then pc0=0x0000 on a cold cache: hit[0]=0, strobe pulses one cycle with addr=0x0000. mfc with rdata=0x1234 arrives in cycle t+6; hit[0]=1 and ir0=0x1234 in t+7.
- Two threads both miss in the same cycle (pc0=0x0003, pc1=0x8005): thread 0 is served first, then thread 1. The next dual miss serves thread 1 first (RR rotation). Exactly two strobes per round.
- Conflict: fill 0x0002, then pc0=0x0012 (same index, new tag) misses. After the fill, 0x0002 misses again.
- Store snoop at snoop_addr=0x0002, snoop_data=0xBEEF on a resident line: ir=0xBEEF the next cycle, no strobe. The same snoop during WAIT for 0x0002 makes the fill write 0xBEEF regardless of rdata.
- inv_all asserted during WAIT: all hits drop to 0 the next cycle, mfc completes with no line written, and the FSM returns to IDLE.
- reset=0 asserted mid-WAIT: strobe=0 and all hits=0 immediately, and a subsequent mfc pulse is ignored.
